alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Registered, handshaked responder for ALU requests, replacing direct combinational ALU access.
- A requester presents operands rda/rdx and an alu_decode opcode with a valid/ready handshake. The block computes the result and returns it on a separate valid/ready response channel.
- Logic, add/sub, shift and compare ops take one cycle. MUL and DIV run iteratively (shift-add / restoring) over WIDTH cycles.
- Sits between the decode/issue stage and writeback.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 8 and a power of two.
- SHW, $clog2(WIDTH), shift-amount bits taken from rdx[SHW-1:0].

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- rda  in  WIDTH  operand A
- rdx  in  WIDTH  operand B / shift amount
- alu_decode  in  4  opcode: 0001 ADD, 0010 SUB, 0101 MUL, 0110 DIV, 0111 OR, 1000 AND, 1001 XOR, 1010 SLL, 1011 SRL, 1100 SLT; all others illegal
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- div_zero  out  1  response is a DIV with rdx==0
- illegal_op  out  1  response is for an undefined opcode

Behaviour:
- Reset is asynchronous and active-low. Clock is clk, reset is rst_n, single clock domain.
- Reset values: state=IDLE, req_ready=0 while rst_n low and 1 once in IDLE, rsp_valid=0, result=0, div_zero=0, illegal_op=0, iteration counter=0.
- State machine:
  - IDLE to EXEC1 for a single-cycle op, MUL, DIV or RESP.
  - MUL / DIV to RESP once the counter reaches WIDTH.
  - RESP to IDLE once rsp_valid && rsp_ready.
- req_ready is 1 only in IDLE. A request is accepted on req_valid && req_ready. rda, rdx and alu_decode are captured at acceptance; later input changes are ignored until the next acceptance.
- Single-cycle ops: the result is registered at acceptance. rsp_valid rises on the next edge, so latency is 1 cycle.
- ADD/SUB are modulo 2^WIDTH (wrap, no flags).
- SLL/SRL are logical, using shift amount rdx[SHW-1:0]; upper rdx bits are ignored.
- SLT is unsigned: result = (rda < rdx) ? 1 : 0, zero-extended.
- MUL is iterative shift-add over WIDTH cycles. result = low WIDTH bits of the product. rsp_valid asserts WIDTH+1 cycles after acceptance.
- DIV is unsigned restoring division, quotient only, WIDTH iterations, same latency as MUL.
- DIV with rdx==0: no iteration. result = all ones, div_zero=1, rsp_valid after 1 cycle.
- Illegal opcode: result=0, illegal_op=1, 1-cycle latency.
- RESP state:
  - result, div_zero and illegal_op stay stable while rsp_valid && !rsp_ready (backpressure, held indefinitely).
  - On the handshake, rsp_valid drops and the FSM returns to IDLE. req_ready rises the cycle after the handshake; there are no back-to-back accepts from RESP.
  - div_zero and illegal_op clear when the FSM leaves RESP.
- Asserting rst_n low mid-MUL/DIV or mid-RESP aborts immediately. The pending response is discarded; no partial result is ever presented.
- Only one transaction is ever in flight.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: MUL uses a single-cycle combinational multiplier (low WIDTH bits), 1-cycle latency like ADD, and the MUL state is unused. DIV stays iterative.
- Undefined: MUL is iterative with WIDTH+1 cycles latency as above.
- All other behaviour is identical in both builds.

Test Plan:
- ADD 5+3, then SUB 5-3, rsp_ready tied 1 -> result 8, then 2, each with rsp_valid exactly 1 cycle after accept. SUB 3-5 -> 32'hFFFFFFFE.
- MUL 5*3 -> 15 after 33 cycles (1 cycle with ALU_FAST_MUL_EN). MUL 32'h10000*32'h10000 -> 0 (wrap).
- DIV 10/2 -> 5 after 33 cycles. DIV 7/0 -> 32'hFFFFFFFF with div_zero=1 after 1 cycle.
- OR/AND/XOR of 32'h55, 32'hAA -> 32'hFF, 0, 32'hFF.
- Shift and compare:
  - SLL 32'h80000000 by rdx=32'h10 -> 0.
  - SRL 32'h00F0F0F0 by 5 -> 32'h00078787.
  - SRL 32'h12345678 by rdx=32'h21 (uses low 5 bits = 1) -> 32'h091A2B3C.
  - SLT FFFFFFFF,1 -> 0.
  - opcode 4'b1111 -> illegal_op=1, result 0.
- Handshake and reset:
  - Hold rsp_ready=0 for 5 cycles after a response -> result stable, req_ready=0, second req_valid not accepted.
  - Drop rst_n at MUL iteration 10 -> all outputs 0 asynchronously, and req_ready=1 the cycle after release.

Source files
------------

// File: rtl/alu_seq_unit_if.sv
// rtl/alu_seq_unit_if.sv - request/response bus for alu_seq_unit
interface alu_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] rda;
    logic [WIDTH-1:0] rdx;
    logic [3:0]       alu_decode;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] result;
    logic             div_zero;
    logic             illegal_op;

    modport master (
        output req_valid, rda, rdx, alu_decode, rsp_ready,
        input  req_ready, rsp_valid, result, div_zero, illegal_op
    );

    modport slave (
        input  req_valid, rda, rdx, alu_decode, rsp_ready,
        output req_ready, rsp_valid, result, div_zero, illegal_op
    );
endinterface

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - handshaked ALU with iterative MUL/DIV (ALU_FAST_MUL_EN: single-cycle MUL)
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_unit_if.slave  io_bus
);
    localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_MUL = 4'b0101,
                           OP_DIV = 4'b0110, OP_OR  = 4'b0111, OP_AND = 4'b1000,
                           OP_XOR = 4'b1001, OP_SLL = 4'b1010, OP_SRL = 4'b1011,
                           OP_SLT = 4'b1100;
    localparam logic [SHW:0] CNT_MAX = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_EXEC1, S_MUL, S_DIV, S_RESP} state_t;

    state_t           r_state, w_next;
    logic             r_run;
    logic [WIDTH-1:0] r_result, r_a, r_b, r_acc;
    logic [SHW:0]     r_cnt;
    logic             r_div_zero, r_illegal;

    logic             w_accept, w_rsp_hs, w_cnt_done;
    logic [WIDTH-1:0] w_alu_res, w_mul_acc, w_rem_sh, w_rem_next;
    logic             w_dz, w_il, w_is_mul, w_is_div, w_div_ge;

    assign io_bus.req_ready  = r_run && (r_state == S_IDLE);
    assign io_bus.rsp_valid  = (r_state == S_RESP);
    assign io_bus.result     = r_result;
    assign io_bus.div_zero   = r_div_zero;
    assign io_bus.illegal_op = r_illegal;

    assign w_accept   = io_bus.req_valid && io_bus.req_ready;
    assign w_rsp_hs   = io_bus.rsp_valid && io_bus.rsp_ready;
    assign w_cnt_done = (r_cnt == CNT_MAX);

    always_comb begin
        w_alu_res = '0;
        w_dz      = 1'b0;
        w_il      = 1'b0;
        w_is_mul  = 1'b0;
        w_is_div  = 1'b0;
        case (io_bus.alu_decode)
            OP_ADD: w_alu_res = io_bus.rda + io_bus.rdx;
            OP_SUB: w_alu_res = io_bus.rda - io_bus.rdx;
`ifdef ALU_FAST_MUL_EN
            OP_MUL: w_alu_res = io_bus.rda * io_bus.rdx;
`else
            OP_MUL: w_is_mul = 1'b1;
`endif
            OP_DIV: begin
                // Divide-by-zero short-circuits to a one-cycle response
                if (io_bus.rdx == '0) begin
                    w_alu_res = '1;
                    w_dz      = 1'b1;
                end else begin
                    w_is_div  = 1'b1;
                end
            end
            OP_OR:  w_alu_res = io_bus.rda | io_bus.rdx;
            OP_AND: w_alu_res = io_bus.rda & io_bus.rdx;
            OP_XOR: w_alu_res = io_bus.rda ^ io_bus.rdx;
            OP_SLL: w_alu_res = io_bus.rda << io_bus.rdx[SHW-1:0];
            OP_SRL: w_alu_res = io_bus.rda >> io_bus.rdx[SHW-1:0];
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, (io_bus.rda < io_bus.rdx)};
            default: w_il = 1'b1;
        endcase
    end

    // r_a holds the shifting multiplicand (MUL) or dividend/quotient (DIV); r_acc the product or remainder
    assign w_mul_acc  = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_rem_sh   = {r_acc[WIDTH-2:0], r_a[WIDTH-1]};
    assign w_div_ge   = r_acc[WIDTH-1] || (w_rem_sh >= r_b);
    assign w_rem_next = w_div_ge ? (w_rem_sh - r_b) : w_rem_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_is_mul ? S_MUL : (w_is_div ? S_DIV : S_EXEC1);
            S_EXEC1: w_next = S_RESP;
            S_MUL:   if (w_cnt_done) w_next = S_RESP;
            S_DIV:   if (w_cnt_done) w_next = S_RESP;
            S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_result   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_div_zero <= w_dz;
                        r_illegal  <= w_il;
                        r_cnt      <= '0;
                        r_a        <= io_bus.rda;
                        r_b        <= io_bus.rdx;
                        r_acc      <= '0;
                        if (!w_is_mul && !w_is_div) r_result <= w_alu_res;
                    end
                end
                S_MUL: begin
                    if (w_cnt_done) begin
                        r_result <= r_acc;
                    end else begin
                        r_acc <= w_mul_acc;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DIV: begin
                    if (w_cnt_done) begin
                        r_result <= r_a;
                    end else begin
                        r_acc <= w_rem_next;
                        r_a   <= {r_a[WIDTH-2:0], w_div_ge};
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_div_zero <= 1'b0;
                        r_illegal  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - self-checking bench for alu_seq_unit
module tb_alu_seq_unit;
    localparam int W   = 32;
    localparam int SHW = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    alu_seq_unit_if #(.WIDTH(W)) bus ();

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the opcode table
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic dz, output logic il, output int lat);
        logic [4:0] sh;
        sh  = b[SHW-1:0];
        r   = '0;
        dz  = 1'b0;
        il  = 1'b0;
        lat = 1;
        case (op)
            4'b0001: r = a + b;
            4'b0010: r = a - b;
            4'b0101: begin
                r = a * b;
`ifndef ALU_FAST_MUL_EN
                lat = W + 1;
`endif
            end
            4'b0110: begin
                if (b == 0) begin
                    r  = '1;
                    dz = 1'b1;
                end else begin
                    r   = a / b;
                    lat = W + 1;
                end
            end
            4'b0111: r = a | b;
            4'b1000: r = a & b;
            4'b1001: r = a ^ b;
            4'b1010: r = a << sh;
            4'b1011: r = a >> sh;
            4'b1100: r = (a < b) ? 1 : 0;
            default: il = 1'b1;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er;
        logic edz, eil;
        int elat, cyc;
        model(op, a, b, er, edz, eil, elat);
        @(negedge clk);
        check({tag, " req_ready"}, 64'(bus.req_ready), 64'(1));
        bus.req_valid  = 1'b1;
        bus.alu_decode = op;
        bus.rda        = a;
        bus.rdx        = b;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.rda        = $urandom;
        bus.rdx        = $urandom;
        bus.alu_decode = 4'($urandom);
        cyc = 0;
        while (!bus.rsp_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(elat));
        check({tag, " result"}, 64'(bus.result), 64'(er));
        check({tag, " div_zero"}, 64'(bus.div_zero), 64'(edz));
        check({tag, " illegal_op"}, 64'(bus.illegal_op), 64'(eil));
        @(negedge clk);
        check({tag, " post rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        check({tag, " post flags"}, 64'({bus.div_zero, bus.illegal_op}), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [10] = '{4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111,
                                 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
        logic [3:0]   op;
        logic [W-1:0] a, b;
        int           cyc;

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.rda        = '0;
        bus.rdx        = '0;
        bus.alu_decode = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset req_ready", 64'(bus.req_ready), 64'(0));
        check("reset rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset result", 64'(bus.result), 64'(0));
        check("reset flags", 64'({bus.div_zero, bus.illegal_op}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("release req_ready", 64'(bus.req_ready), 64'(1));

        run_op("add 5+3", 4'b0001, 5, 3);
        run_op("sub 5-3", 4'b0010, 5, 3);
        run_op("sub 3-5", 4'b0010, 3, 5);
        run_op("mul 5*3", 4'b0101, 5, 3);
        run_op("mul wrap", 4'b0101, 32'h10000, 32'h10000);
        run_op("div 10/2", 4'b0110, 10, 2);
        run_op("div 7/0", 4'b0110, 7, 0);
        run_op("or", 4'b0111, 32'h55, 32'hAA);
        run_op("and", 4'b1000, 32'h55, 32'hAA);
        run_op("xor", 4'b1001, 32'h55, 32'hAA);
        run_op("sll out", 4'b1010, 32'h80000000, 32'h10);
        run_op("srl 5", 4'b1011, 32'h00F0F0F0, 5);
        run_op("srl wrapamt", 4'b1011, 32'h12345678, 32'h21);
        run_op("slt ffff,1", 4'b1100, 32'hFFFFFFFF, 1);
        run_op("illegal", 4'b1111, 32'h1234, 32'h5678);

        for (int i = 0; i < 40; i++) begin
            op = (i % 8 == 7) ? 4'b0000 : ops[$urandom_range(0, 9)];
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
            run_op("random", op, a, b);
        end

        // Backpressure: response held, second request ignored
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.alu_decode = 4'b0001;
        bus.rda        = 100;
        bus.rdx        = 23;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        cyc = 0;
        while (!bus.rsp_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("bp latency", 64'(cyc), 64'(1));
        for (int i = 0; i < 5; i++) begin
            bus.req_valid  = 1'b1;
            bus.alu_decode = 4'b0010;
            bus.rda        = $urandom;
            bus.rdx        = $urandom;
            @(negedge clk);
            check("bp result", 64'(bus.result), 64'(123));
            check("bp rsp_valid", 64'(bus.rsp_valid), 64'(1));
            check("bp req_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp release rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("bp release req_ready", 64'(bus.req_ready), 64'(1));

        // Asynchronous reset in the middle of a MUL
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.alu_decode = 4'b0101;
        bus.rda        = 32'h1234;
        bus.rdx        = 32'h777;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("abort req_ready", 64'(bus.req_ready), 64'(0));
        check("abort result", 64'(bus.result), 64'(0));
        check("abort flags", 64'({bus.div_zero, bus.illegal_op}), 64'(0));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort held req_ready", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        check("abort after req_ready", 64'(bus.req_ready), 64'(1));
        check("abort after rsp_valid", 64'(bus.rsp_valid), 64'(0));
        run_op("post reset mul", 4'b0101, 32'hFFFF, 32'h3);
        run_op("post reset div", 4'b0110, 32'hFFFFFFFF, 32'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
